// File: rtl/trap_ctrl_if.sv
// Signal bundle between the trap sequencer and the pipeline/CSR file.
// slave = trap_ctrl side, master = the pipeline/CSR side driving it.
interface trap_ctrl_if #(
  parameter int XLEN = 32
);
  logic            ext_irq;
  logic            timer_irq;
  logic            mstatus_mie;
  logic            mie_meie;
  logic            mie_mtie;
  logic [XLEN-1:0] mtvec;
  logic [XLEN-1:0] mepc_in;
  logic [XLEN-1:0] pc_exec;
  logic            inst_valid;
  logic            stall;
  logic            is_mret;

  logic            mepc_wr;
  logic [XLEN-1:0] mepc_wdata;
  logic            mcause_wr;
  logic [XLEN-1:0] mcause_wdata;
  logic            mstatus_trap;
  logic            mstatus_mret;
  logic            flush;
  logic            pc_redirect;
  logic [XLEN-1:0] redirect_pc;
  logic            busy;

  modport slave (
    input  ext_irq, timer_irq, mstatus_mie, mie_meie, mie_mtie, mtvec, mepc_in,
           pc_exec, inst_valid, stall, is_mret,
    output mepc_wr, mepc_wdata, mcause_wr, mcause_wdata, mstatus_trap,
           mstatus_mret, flush, pc_redirect, redirect_pc, busy
  );

  modport master (
    output ext_irq, timer_irq, mstatus_mie, mie_meie, mie_mtie, mtvec, mepc_in,
           pc_exec, inst_valid, stall, is_mret,
    input  mepc_wr, mepc_wdata, mcause_wr, mcause_wdata, mstatus_trap,
           mstatus_mret, flush, pc_redirect, redirect_pc, busy
  );
endinterface

// File: rtl/trap_ctrl.sv
// Machine-mode interrupt entry / MRET sequencer: synchronises the irq pins,
// arbitrates against MRET and drives registered CSR strobes and PC redirect.
module trap_ctrl #(
  parameter int XLEN        = 32,
  parameter int SYNC_STAGES = 2
) (
  input logic        clk,
  input logic        rst,
  trap_ctrl_if.slave bus
);
  typedef enum logic [2:0] {
    S_IDLE,
    S_SAVE,
    S_REDIRECT,
    S_MRET,
    S_HOLD
  } state_t;

  typedef struct packed {
    logic            mepc_wr;
    logic [XLEN-1:0] mepc_wdata;
    logic            mcause_wr;
    logic [XLEN-1:0] mcause_wdata;
    logic            mstatus_trap;
    logic            mstatus_mret;
    logic            flush;
    logic            pc_redirect;
    logic [XLEN-1:0] redirect_pc;
    logic            busy;
  } out_t;

  localparam logic [3:0] CAUSE_EXT = 4'd11;
  localparam logic [3:0] CAUSE_TMR = 4'd7;

  state_t                 r_state;
  state_t                 w_next_state;
  logic [SYNC_STAGES-1:0] r_ext_sync;
  logic [SYNC_STAGES-1:0] r_tmr_sync;
  logic [3:0]             r_cause;
  out_t                   r_out;
  out_t                   w_out;

  logic            w_pend_ext;
  logic            w_pend_tmr;
  logic            w_take_irq;
  logic            w_take_mret;
  logic [3:0]      w_cause;
  logic [XLEN-1:0] w_base;
  logic [XLEN-1:0] w_vector;

  assign w_pend_ext  = r_ext_sync[SYNC_STAGES-1] & bus.mie_meie;
  assign w_pend_tmr  = r_tmr_sync[SYNC_STAGES-1] & bus.mie_mtie;
  assign w_take_irq  = bus.mstatus_mie & (w_pend_ext | w_pend_tmr) & bus.inst_valid & ~bus.stall;
  assign w_take_mret = bus.is_mret & bus.inst_valid & ~bus.stall;
  assign w_cause     = w_pend_ext ? CAUSE_EXT : CAUSE_TMR;

  // Reserved modes 2/3 fall back to direct mode.
  assign w_base   = {bus.mtvec[XLEN-1:2], 2'b00};
  assign w_vector = (bus.mtvec[1:0] == 2'd1) ? w_base + XLEN'({r_cause, 2'b00}) : w_base;

  always_comb begin
    w_next_state = r_state;
    case (r_state)
      S_IDLE: begin
        if (w_take_mret)     w_next_state = S_MRET;
        else if (w_take_irq) w_next_state = S_SAVE;
      end
      S_SAVE:     w_next_state = S_REDIRECT;
      S_REDIRECT: w_next_state = S_HOLD;
      S_MRET:     w_next_state = S_HOLD;
      S_HOLD:     w_next_state = S_IDLE;
      default:    w_next_state = S_IDLE;
    endcase
  end

  // Outputs are decoded from the next state so they leave a flop in the
  // same cycle the state register enters that state.
  always_comb begin
    // NOTE: every field gets a default first so no path leaves a latch.
    w_out      = '0;
    w_out.busy = (w_next_state != S_IDLE);
    case (w_next_state)
      S_SAVE: begin
        w_out.mepc_wr      = 1'b1;
        w_out.mepc_wdata   = bus.pc_exec;
        w_out.mcause_wr    = 1'b1;
        w_out.mcause_wdata = {1'b1, (XLEN-1)'(w_cause)};
        w_out.mstatus_trap = 1'b1;
        w_out.flush        = 1'b1;
      end
      S_REDIRECT: begin
        w_out.pc_redirect = 1'b1;
        w_out.flush       = 1'b1;
        w_out.redirect_pc = w_vector;
      end
      S_MRET: begin
        w_out.pc_redirect  = 1'b1;
        w_out.flush        = 1'b1;
        w_out.redirect_pc  = bus.mepc_in;
        w_out.mstatus_mret = 1'b1;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments only.
    if (rst) begin
      r_state    <= S_IDLE;
      r_ext_sync <= '0;
      r_tmr_sync <= '0;
      r_cause    <= '0;
      r_out      <= '0;
    end else begin
      r_state    <= w_next_state;
      r_ext_sync <= {r_ext_sync[SYNC_STAGES-2:0], bus.ext_irq};
      r_tmr_sync <= {r_tmr_sync[SYNC_STAGES-2:0], bus.timer_irq};
      r_out      <= w_out;
      if (r_state == S_IDLE && w_next_state == S_SAVE) r_cause <= w_cause;
    end
  end

  assign bus.mepc_wr      = r_out.mepc_wr;
  assign bus.mepc_wdata   = r_out.mepc_wdata;
  assign bus.mcause_wr    = r_out.mcause_wr;
  assign bus.mcause_wdata = r_out.mcause_wdata;
  assign bus.mstatus_trap = r_out.mstatus_trap;
  assign bus.mstatus_mret = r_out.mstatus_mret;
  assign bus.flush        = r_out.flush;
  assign bus.pc_redirect  = r_out.pc_redirect;
  assign bus.redirect_pc  = r_out.redirect_pc;
  assign bus.busy         = r_out.busy;
endmodule
